// File: rtl/unpack_scheduler_if.sv
// ---------------------------------------------------------------------------
// unpack_scheduler_if
// Bundles the two requester ports and the result port of unpack_scheduler.
//   req0_* / req1_* : valid/ready request ports (add/sub = 0, mul/div = 1)
//                     carrying 64-bit operands fa/fb, db, normal and a tag
//   out_*           : registered unpacked result with valid/ready handshake
// Modports:
//   master : requesters + downstream consumer (drives requests and out_ready)
//   slave  : the scheduler itself
// ---------------------------------------------------------------------------
interface unpack_scheduler_if #(
  parameter int TAGW = 4
);
  logic            req0_valid, req1_valid;
  logic            req0_ready, req1_ready;
  logic [63:0]     req0_fa, req0_fb, req1_fa, req1_fb;
  logic            req0_db, req1_db;
  logic            req0_normal, req1_normal;
  logic [TAGW-1:0] req0_tag, req1_tag;

  logic            out_valid, out_ready, out_id;
  logic [TAGW-1:0] out_tag;
  logic            out_sa, out_sb;
  logic [10:0]     out_ea, out_eb;
  logic [5:0]      out_lza, out_lzb;
  logic [52:0]     out_fa, out_fb;
  logic [3:0]      out_fla, out_flb;
  logic [52:0]     out_nan;

  modport master (
    output req0_valid, req1_valid, req0_fa, req0_fb, req1_fa, req1_fb,
           req0_db, req1_db, req0_normal, req1_normal, req0_tag, req1_tag,
           out_ready,
    input  req0_ready, req1_ready, out_valid, out_id, out_tag,
           out_sa, out_sb, out_ea, out_eb, out_lza, out_lzb,
           out_fa, out_fb, out_fla, out_flb, out_nan
  );

  modport slave (
    input  req0_valid, req1_valid, req0_fa, req0_fb, req1_fa, req1_fb,
           req0_db, req1_db, req0_normal, req1_normal, req0_tag, req1_tag,
           out_ready,
    output req0_ready, req1_ready, out_valid, out_id, out_tag,
           out_sa, out_sb, out_ea, out_eb, out_lza, out_lzb,
           out_fa, out_fb, out_fla, out_flb, out_nan
  );
endinterface

// File: rtl/unpack_scheduler.sv
// ---------------------------------------------------------------------------
// unpack_scheduler
// Arbitrates two requesters in front of the shared combinational operand
// unpacker, latches the winning operand pair, and registers the unpacked
// result together with the requester id and tag.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : unpack_scheduler_if.slave (request ports + result port)
// Build option:
//   UNPACK_SCHED_RR_EN defined   -> round-robin on ties (uses 'last' register)
//   UNPACK_SCHED_RR_EN undefined -> fixed priority, port 0 wins ties
// Also contains:
//   unpack_operand : unpacks one IEEE operand (double, or packed single in
//                    bits [63:32]) into sign/exponent/lz/significand/class
//   unpackermaster : two unpack_operand lanes plus quiet-NaN selection
// ---------------------------------------------------------------------------

module unpack_operand (
  input  logic [63:0] x,
  input  logic        db,
  input  logic        normal,
  output logic        s,
  output logic [10:0] e,
  output logic [5:0]  lz,
  output logic [52:0] raw,
  output logic [52:0] sig,
  output logic [3:0]  fl
);
  logic [51:0] frac;
  logic        emax, ezero, fnz;

  // Single precision keeps its native 8-bit biased exponent and places the
  // 23-bit fraction at the top of the 52-bit fraction field.
  always_comb begin
    if (db) begin
      e     = x[62:52];
      frac  = x[51:0];
      emax  = &x[62:52];
      ezero = ~|x[62:52];
    end else begin
      e     = {3'b000, x[62:55]};
      frac  = {x[54:32], 29'b0};
      emax  = &x[62:55];
      ezero = ~|x[62:55];
    end
  end

  assign s   = x[63];
  assign fnz = |frac;
  assign raw = {~ezero, frac};

  // Leading zeros of the 53-bit significand; 53 when it is all zero.
  always_comb begin
    lz = 6'd53;
    for (int i = 0; i < 53; i++) begin
      if (raw[i]) lz = 6'(52 - i);
    end
  end

  // Normal mode left-justifies denormal significands.
  assign sig = normal ? (raw << lz) : raw;
  // Class flags: {nan, inf, zero, denormal}
  assign fl  = {emax & fnz, emax & ~fnz, ezero & ~fnz, ezero & fnz};
endmodule

module unpackermaster (
  input  logic [63:0] fa,
  input  logic [63:0] fb,
  input  logic        db,
  input  logic        normal,
  output logic        sa, sb,
  output logic [10:0] ea, eb,
  output logic [5:0]  lza, lzb,
  output logic [52:0] sfa, sfb,
  output logic [3:0]  fla, flb,
  output logic [52:0] nan
);
  localparam logic [52:0] QNAN_DEFAULT = 53'h18000000000000;
  localparam logic [52:0] QUIET_BIT    = 53'h08000000000000;

  logic [1:0][63:0] x;
  logic [1:0]       s;
  logic [1:0][10:0] e;
  logic [1:0][5:0]  lz;
  logic [1:0][52:0] raw, sig;
  logic [1:0][3:0]  fl;

  assign x[0] = fa;
  assign x[1] = fb;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      unpack_operand u_op (
        .x(x[gi]), .db(db), .normal(normal),
        .s(s[gi]), .e(e[gi]), .lz(lz[gi]),
        .raw(raw[gi]), .sig(sig[gi]), .fl(fl[gi])
      );
    end
  endgenerate

  assign {sa, ea, lza, sfa, fla} = {s[0], e[0], lz[0], sig[0], fl[0]};
  assign {sb, eb, lzb, sfb, flb} = {s[1], e[1], lz[1], sig[1], fl[1]};

  // NaN propagation: operand A has precedence, payload is quieted.
  assign nan = fl[0][3] ? (raw[0] | QUIET_BIT) :
               fl[1][3] ? (raw[1] | QUIET_BIT) : QNAN_DEFAULT;
endmodule

module unpack_scheduler #(
  parameter int TAGW = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  unpack_scheduler_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, UNPACK, DONE} state_t;

  state_t          state_reg, state_next;
  logic            grant_open, pick1, take0, take1, take;

  logic [63:0]     op_fa_reg, op_fb_reg;
  logic            op_db_reg, op_normal_reg, op_id_reg;
  logic [TAGW-1:0] op_tag_reg;

  logic            res_sa, res_sb;
  logic [10:0]     res_ea, res_eb;
  logic [5:0]      res_lza, res_lzb;
  logic [52:0]     res_fa, res_fb, res_nan;
  logic [3:0]      res_fla, res_flb;

  logic            out_valid_reg, out_id_reg, out_sa_reg, out_sb_reg;
  logic [TAGW-1:0] out_tag_reg;
  logic [10:0]     out_ea_reg, out_eb_reg;
  logic [5:0]      out_lza_reg, out_lzb_reg;
  logic [52:0]     out_fa_reg, out_fb_reg, out_nan_reg;
  logic [3:0]      out_fla_reg, out_flb_reg;

`ifdef UNPACK_SCHED_RR_EN
  logic last_reg;   // id of the most recent grant

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last_reg <= 1'b1;
    else if (take) last_reg <= take1;
  end
`endif

  always_comb begin
    // Grants are possible in IDLE, or in DONE in the same cycle the held
    // result is consumed. Gated by rst_n so nothing is granted in reset.
    grant_open = rst_n && ((state_reg == IDLE) ||
                           ((state_reg == DONE) && bus.out_ready));
`ifdef UNPACK_SCHED_RR_EN
    pick1 = bus.req1_valid && (!bus.req0_valid || !last_reg);
`else
    pick1 = bus.req1_valid && !bus.req0_valid;
`endif
    take1 = grant_open && pick1;
    take0 = grant_open && bus.req0_valid && !pick1;
    take  = take0 || take1;

    state_next = state_reg;
    case (state_reg)
      IDLE:    if (take) state_next = UNPACK;
      UNPACK:  state_next = DONE;
      DONE:    if (bus.out_ready) state_next = take ? UNPACK : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.req0_ready = take0;
  assign bus.req1_ready = take1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Operand register: loaded on every accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_fa_reg     <= '0;
      op_fb_reg     <= '0;
      op_db_reg     <= 1'b0;
      op_normal_reg <= 1'b0;
      op_tag_reg    <= '0;
      op_id_reg     <= 1'b0;
    end else if (take) begin
      op_fa_reg     <= take1 ? bus.req1_fa     : bus.req0_fa;
      op_fb_reg     <= take1 ? bus.req1_fb     : bus.req0_fb;
      op_db_reg     <= take1 ? bus.req1_db     : bus.req0_db;
      op_normal_reg <= take1 ? bus.req1_normal : bus.req0_normal;
      op_tag_reg    <= take1 ? bus.req1_tag    : bus.req0_tag;
      op_id_reg     <= take1;
    end
  end

  unpackermaster u_unpack (
    .fa(op_fa_reg), .fb(op_fb_reg), .db(op_db_reg), .normal(op_normal_reg),
    .sa(res_sa), .sb(res_sb), .ea(res_ea), .eb(res_eb),
    .lza(res_lza), .lzb(res_lzb), .sfa(res_fa), .sfb(res_fb),
    .fla(res_fla), .flb(res_flb), .nan(res_nan)
  );

  // Result register: captured at the end of UNPACK and held through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_id_reg    <= 1'b0;
      out_tag_reg   <= '0;
      out_sa_reg    <= 1'b0;
      out_sb_reg    <= 1'b0;
      out_ea_reg    <= '0;
      out_eb_reg    <= '0;
      out_lza_reg   <= '0;
      out_lzb_reg   <= '0;
      out_fa_reg    <= '0;
      out_fb_reg    <= '0;
      out_fla_reg   <= '0;
      out_flb_reg   <= '0;
      out_nan_reg   <= '0;
    end else if (state_reg == UNPACK) begin
      out_valid_reg <= 1'b1;
      out_id_reg    <= op_id_reg;
      out_tag_reg   <= op_tag_reg;
      out_sa_reg    <= res_sa;
      out_sb_reg    <= res_sb;
      out_ea_reg    <= res_ea;
      out_eb_reg    <= res_eb;
      out_lza_reg   <= res_lza;
      out_lzb_reg   <= res_lzb;
      out_fa_reg    <= res_fa;
      out_fb_reg    <= res_fb;
      out_fla_reg   <= res_fla;
      out_flb_reg   <= res_flb;
      out_nan_reg   <= res_nan;
    end else if ((state_reg == DONE) && bus.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_id    = out_id_reg;
  assign bus.out_tag   = out_tag_reg;
  assign bus.out_sa    = out_sa_reg;
  assign bus.out_sb    = out_sb_reg;
  assign bus.out_ea    = out_ea_reg;
  assign bus.out_eb    = out_eb_reg;
  assign bus.out_lza   = out_lza_reg;
  assign bus.out_lzb   = out_lzb_reg;
  assign bus.out_fa    = out_fa_reg;
  assign bus.out_fb    = out_fb_reg;
  assign bus.out_fla   = out_fla_reg;
  assign bus.out_flb   = out_flb_reg;
  assign bus.out_nan   = out_nan_reg;
endmodule

// File: doc/unpack_scheduler.md
# unpack_scheduler

Sequencing and arbitration controller in front of the shared operand unpacker (`unpackermaster`). Two requesters, the add/sub unit (port 0) and the mul/div unit (port 1), issue 64-bit operand pairs through valid/ready handshakes. The block arbitrates between them, latches the winning operand pair, drives the internally instantiated combinational `unpackermaster`, and registers its results with the requester id. Results are presented to the downstream exponent/significand stage.

## Interface
Parameters:
- `TAGW`, default 4: width of the per-request tag returned with the result.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req0_valid`, `req1_valid`  in  1  request present on port 0 / port 1.
- `req0_ready`, `req1_ready`  out  1  port accepts this cycle.
- `req0_fa`, `req0_fb`, `req1_fa`, `req1_fb`  in  64  packed operands A/B.
- `req0_db`, `req1_db`  in  1  1 selects double, 0 selects packed single.
- `req0_normal`, `req1_normal`  in  1  normal-mode flag, passed to the unpacker.
- `req0_tag`, `req1_tag`  in  TAGW  opaque tag.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  downstream consumes.
- `out_id`  out  1  requester that owns the result.
- `out_tag`  out  TAGW  tag of that request.
- `out_sa`, `out_sb`  out  1  signs.
- `out_ea`, `out_eb`  out  11  exponents.
- `out_lza`, `out_lzb`  out  6  leading-zero counts.
- `out_fa`, `out_fb`  out  53  significands.
- `out_fla`, `out_flb`  out  4  class flags.
- `out_nan`  out  53  quiet-NaN significand.

## Operation
- The FSM has three states: IDLE, UNPACK, DONE. The reset state is IDLE.
- IDLE: if any `reqN_valid` is high, the arbiter picks a winner. The winning `reqN_ready` is high that cycle. The block latches the winner's fa, fb, db, normal, tag and id into the operand register, then goes to UNPACK.
- UNPACK: the latched operands drive `unpackermaster`. At the clock edge, all unpacker outputs, the id and the tag load into the result register, and `out_valid` is set. The state goes to DONE. No request is accepted in UNPACK.
- DONE: `out_valid`=1 and all `out_*` are held stable until `out_ready`=1.
  - If `out_ready`=1 and a request is valid, the block arbitrates and accepts in the same cycle (ready asserted), then goes to UNPACK. `out_valid` drops at the edge.
  - If `out_ready`=1 and no request is valid, the state goes to IDLE.
- `reqN_ready` is combinational: high only for the arbitration winner, in IDLE, or in DONE with `out_ready`=1. A request is accepted only when valid and ready are both high on an edge.
- Arbitration uses the `last` register, which holds the id of the most recent grant and resets to 1.
  - Only one request is valid: that request wins.
  - Both are valid: the winner is `~last` (round-robin, see Configuration).
  - `last` updates only on an accepted grant.
- Operands are never modified by this block. Single-precision packing (db=0) is interpreted entirely by `unpackermaster`.
- Reset values: state IDLE, `last`=1, and `out_valid`, `out_id`, `out_tag` and every `out_*` datapath register = 0. `req0_ready`=`req1_ready`=0 while `rst_n`=0.
- Reset asserted mid-operation: any latched or held operation is discarded immediately. No result is emitted after release.

## Timing
- Latency: a request accepted at edge k gives `out_valid`=1 after edge k+1.
- Throughput: one operation per 2 cycles when `out_ready` is tied high.
- Backpressure: while `out_ready`=0, the result is held indefinitely. Both ready outputs stay 0 and requesters must hold valid/data.
- Both requesters valid every cycle: grants alternate 0,1,0,1… (round-robin build). Neither port waits more than one foreign grant.
- A valid request withdrawn before acceptance is not an error. Behaviour is defined only by valid&&ready at the edge.

## Configuration
- `UNPACK_SCHED_RR_EN` defined: round-robin arbitration as described, using the `last` register.
- `UNPACK_SCHED_RR_EN` undefined: fixed priority, port 0 always wins ties. The `last` register is not implemented. All other behaviour is identical.

## Test plan
- Reset and single request: hold `rst_n`=0 and check every output is 0. Release, then drive req0 with fa=fb=64'h4008000000000000, db=1, normal=1, tag=3.
  - `req0_ready`=1 in the first cycle.
  - `out_valid`=1 two edges later with `out_id`=0 and `out_tag`=3.
  - All `out_*` equal a standalone golden `unpackermaster` fed the same inputs (expected ea=11'h400, fa=53'h18000000000000).
- Contention (RR build): hold both valid continuously with `out_ready`=1 and distinct tags. The `out_id` sequence is 0,1,0,1 and one result appears every 2 cycles.
- Fixed-priority build: same stimulus as contention. `out_id` is always 0 and `req1_ready` is never 1.
- Backpressure: with `out_ready`=0 for 5 cycles, `out_*` stay stable and both readys are 0. Raise `out_ready` with req1 valid: req1 is accepted in the same cycle and `out_valid` drops for exactly one cycle.
- Single precision: req1 sends fa=fb=64'h42C8000042C80000 with db=0. Outputs match the golden unpacker with db=0 and `out_id`=1.
- Mid-operation reset: assert `rst_n`=0 during UNPACK. Outputs go to 0 immediately, and after release `out_valid` stays 0 until a new request is accepted.
